// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared definitions for the pipe_MIPS32 data-memory responder.
//   state_t          responder FSM states (IDLE/WAIT/ACCESS/RESP = 0..3)
//   MIPS_DATA_W      default data word width
//   MIPS_MEM_ADDR_W  default word-address width (depth = 2**MIPS_MEM_ADDR_W)
package mips_mem_pkg;

  localparam int unsigned MIPS_DATA_W     = 32;
  localparam int unsigned MIPS_MEM_ADDR_W = 10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

endpackage

// File: rtl/mips_mem_array.sv
// mips_mem_array: single-port synchronous word RAM with registered read.
// Storage is Mem[]; with MEM_PARITY_EN defined a shadow even-parity bit
// Mem_par[] is written on every store and checked on every read.
//   clk    in   rising-edge clock
//   rst_n  in   async active-low reset (read registers only, not storage)
//   we     in   write Mem[addr] <= wdata
//   re     in   capture Mem[addr] into rdata
//   addr   in   word index
//   wdata  in   store data
//   rdata  out  registered read data
//   par_err out registered parity fault of the last read (0 without MEM_PARITY_EN)
module mips_mem_array
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = MIPS_MEM_ADDR_W,
  parameter int unsigned DATA_W = MIPS_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              par_err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] Mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) Mem[addr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= Mem[addr];
  end

`ifdef MEM_PARITY_EN
  logic Mem_par [DEPTH];

  always_ff @(posedge clk) begin
    if (we) Mem_par[addr] <= ^wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  par_err <= 1'b0;
    else if (re) par_err <= (^Mem[addr]) != Mem_par[addr];
  end
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: rtl/mips_mem_responder.sv
// mips_mem_responder: word-addressed data-memory target for the MEM stage.
// One LW/SW at a time: accept over req_valid/req_ready, wait LATENCY cycles,
// access the array for one cycle, then hold the response until rsp_ready.
// Optional macro MEM_PARITY_EN adds per-word parity; a load with bad parity
// returns the raw word with rsp_err=1.
//   clk1       in   clock, rising edge
//   rst_n      in   async active-low reset
//   req_valid  in   request present          req_ready out  can accept
//   req_we     in   1=store, 0=load          req_addr  in   32-bit word address
//   req_wdata  in   store data
//   rsp_valid  out  response present         rsp_ready in   response accepted
//   rsp_rdata  out  load data (0 for stores/range errors)
//   rsp_err    out  out-of-range address or parity fault
module mips_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = MIPS_MEM_ADDR_W,
  parameter int unsigned DATA_W  = MIPS_DATA_W,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  state_t            state, state_nxt;
  logic [3:0]        cnt;
  logic              we_q;
  logic [31:0]       addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              range_err_q;
  logic              in_range;
  logic              mem_we, mem_re;
  logic [DATA_W-1:0] arr_rdata;
  logic              arr_par_err;

  // Upper address bits only feed the range check; the low bits index Mem.
  assign in_range = (addr_q >> ADDR_W) == '0;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      range_err_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt     <= 4'(LATENCY);
          end
        end
        S_WAIT:   cnt         <= cnt - 4'd1;
        S_ACCESS: range_err_q <= !in_range;
        default:  ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = (LATENCY == 0) ? S_ACCESS : S_WAIT;
      end
      S_WAIT: begin
        if (cnt == 4'd1) state_nxt = S_ACCESS;
      end
      S_ACCESS: begin
        mem_we    = we_q && in_range;
        mem_re    = !we_q && in_range;
        state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Response fields are decoded from registers that only change outside RESP,
  // so they stay stable for as long as rsp_ready is held low.
  assign rsp_rdata = (rsp_valid && !we_q && !range_err_q) ? arr_rdata : '0;
  assign rsp_err   = rsp_valid && (range_err_q || (!we_q && arr_par_err));

  mips_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk     (clk1),
    .rst_n   (rst_n),
    .we      (mem_we),
    .re      (mem_re),
    .addr    (addr_q[ADDR_W-1:0]),
    .wdata   (wdata_q),
    .rdata   (arr_rdata),
    .par_err (arr_par_err)
  );

endmodule

// File: tb/tb_mips_mem_responder.sv
// Bench for mips_mem_responder: directed scenarios followed by random
// loads/stores, checked against an array model of the memory contents.
module tb_mips_mem_responder;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LAT    = 2;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic              clk1 = 1'b0;
  logic              rst_n;
  logic              req_valid, req_ready, req_we;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid, rsp_ready, rsp_err;
  logic [DATA_W-1:0] rsp_rdata;

  logic [DATA_W-1:0] model_mem [DEPTH];
  logic              model_bad [DEPTH];
  int unsigned       n_cmp = 0;
  int unsigned       n_bad = 0;

  always #5 clk1 = ~clk1;

  mips_mem_responder #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .LATENCY (LAT)
  ) dut (
    .clk1      (clk1),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("%s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int unsigned idx, input logic [DATA_W-1:0] val);
    dut.u_array.Mem[idx] = val;
`ifdef MEM_PARITY_EN
    dut.u_array.Mem_par[idx] = ^val;
`endif
    model_mem[idx] = val;
    model_bad[idx] = 1'b0;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge, DUT idle again.
  task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                     input logic [DATA_W-1:0] wdata, input int unsigned hold);
    logic              exp_err;
    logic [DATA_W-1:0] exp_data;
    logic [DATA_W-1:0] d0;
    logic              e0;
    int unsigned       idx;
    int unsigned       cyc;

    idx      = addr % DEPTH;
    exp_err  = addr >= DEPTH;
    exp_data = '0;
    if (!exp_err) begin
      if (we) begin
        model_mem[idx] = wdata;
        model_bad[idx] = 1'b0;
      end else begin
        exp_data = model_mem[idx];
`ifdef MEM_PARITY_EN
        exp_err  = model_bad[idx];
`endif
      end
    end

    check({tag, ".idle_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    @(negedge clk1);
    req_valid = 1'b0;
    req_wdata = $urandom;
    cyc = 1;
    check({tag, ".busy_ready"}, 32'(req_ready), 32'd0);
    while (!rsp_valid && cyc < 40) begin
      @(negedge clk1);
      cyc++;
    end
    // Cycles from the handshake cycle to the first cycle with rsp_valid high.
    check({tag, ".latency"}, cyc, LAT + 2);
    check({tag, ".rdata"}, rsp_rdata, exp_data);
    check({tag, ".err"}, 32'(rsp_err), 32'(exp_err));
    d0 = rsp_rdata;
    e0 = rsp_err;
    for (int h = 0; h < int'(hold); h++) begin
      @(negedge clk1);
      check({tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, ".hold_rdata"}, rsp_rdata, d0);
      check({tag, ".hold_err"}, 32'(rsp_err), 32'(e0));
      check({tag, ".hold_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk1);
    rsp_ready = 1'b0;
    check({tag, ".done_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, ".done_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0]       a;
    logic [DATA_W-1:0] v, old5, old0;
    int unsigned       sel;

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) preload(i, $urandom);
    repeat (3) @(negedge clk1);
    check("rst.req_ready", 32'(req_ready), 32'd1);
    check("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst.rsp_rdata", rsp_rdata, 32'd0);
    check("rst.rsp_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk1);

    // Basic load.
    preload(120, 32'd85);
    txn("t1_lw120", 1'b0, 32'd120, '0, 0);

    // Store then load of the same word.
    txn("t2_sw121", 1'b1, 32'd121, 32'd130, 0);
    txn("t2_lw121", 1'b0, 32'd121, '0, 0);

    // Out-of-range: must not alias onto word 0.
    old0 = model_mem[0];
    txn("t3_lw400", 1'b0, 32'h0000_0400, '0, 0);
    txn("t3_sw400", 1'b1, 32'h0000_0400, ~old0, 0);
    check("t3.mem0", dut.u_array.Mem[0], old0);
    txn("t3_lw0", 1'b0, 32'd0, '0, 0);

    // Backpressure on the response channel.
    txn("t4_hold", 1'b0, 32'd120, '0, 5);

    // Reset during WAIT discards the store.
    old5 = 32'hDEAD_0005;
    preload(5, old5);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'd5;
    req_wdata = 32'd7;
    @(negedge clk1);
    req_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("t5.req_ready", 32'(req_ready), 32'd1);
    check("t5.rsp_valid", 32'(rsp_valid), 32'd0);
    check("t5.rsp_rdata", rsp_rdata, 32'd0);
    check("t5.rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk1);
    check("t5.mem5", dut.u_array.Mem[5], old5);
    txn("t5_lw5", 1'b0, 32'd5, '0, 0);

    // Parity fault on a preloaded word (no effect without parity support).
    v = 32'h1234_5679;
    preload(10, v);
`ifdef MEM_PARITY_EN
    dut.u_array.Mem_par[10] = ~(^v);
    model_bad[10] = 1'b1;
`endif
    txn("t6_lw10", 1'b0, 32'd10, '0, 0);
    txn("t6_sw10", 1'b1, 32'd10, v, 0);
    txn("t6_lw10b", 1'b0, 32'd10, '0, 0);

    // Random mix, biased toward a few hot words for store/load reuse.
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        a = $urandom;
        if (a < DEPTH) a = a | 32'h0000_0400;
      end else if (sel < 5) begin
        a = $urandom_range(0, 7);
      end else begin
        a = $urandom_range(0, DEPTH - 1);
      end
      txn($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), a, $urandom,
          $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
